// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK carrier modulator: bipolar symbol codes, default
// widths, the elaboration-time sine table generator and the symmetric saturation helper.
package qpsk_pkg;

    localparam logic [1:0] BP_POS = 2'b01;
    localparam logic [1:0] BP_NEG = 2'b11;

    localparam int PHASE_W_DEF = 24;
    localparam int LUT_AW_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int FTW_DEF     = 3355;

    localparam longint TRIG_ONE = 64'sd1 <<< 28;
    localparam longint PI_FX    = 64'sd843314857;   // pi in Q28

    // round(amp*sin(2*pi*k/2^aw)) in integer arithmetic: first-quadrant Taylor series
    // mirrored into the other three quadrants, so 0/90/180/270 degrees come out exact.
    function automatic int sin_entry(input int k, input int aw, input int amp);
        int     quarter, kk, q, r;
        longint x, x2, term, sum, mag;
        quarter = 1 << (aw - 2);
        kk      = k % (quarter * 4);
        q       = kk / quarter;
        r       = kk % quarter;
        if (q == 1 || q == 3) r = quarter - r;
        x    = (PI_FX * longint'(r)) / longint'(2 * quarter);
        x2   = (x * x) / TRIG_ONE;
        term = x;
        sum  = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) / TRIG_ONE) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        mag = (longint'(amp) * sum + TRIG_ONE / 2) / TRIG_ONE;
        return (q >= 2) ? -int'(mag) : int'(mag);
    endfunction

    // Clamp to the symmetric range [-(2^w-1), 2^w-1].
    function automatic int sat_sym(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/qpsk_sin_rom.sv
// Dual-read-port sine ROM (2^LUT_AW x DATA_W) with registered outputs, one cycle of
// read latency. The table is generated at elaboration from qpsk_pkg::sin_entry.
module qpsk_sin_rom
    import qpsk_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LUT_AW-1:0]        i_sin_addr,
    input  logic [LUT_AW-1:0]        i_cos_addr,
    output logic signed [DATA_W-1:0] o_sin,
    output logic signed [DATA_W-1:0] o_cos
);

    localparam int DEPTH = 1 << LUT_AW;
    localparam int AMP   = (1 << (DATA_W - 1)) - 1;

    logic signed [DATA_W-1:0] w_table [DEPTH];
    logic signed [DATA_W-1:0] r_sin;
    logic signed [DATA_W-1:0] r_cos;

    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        assign w_table[k] = DATA_W'(sin_entry(k, LUT_AW, AMP));
    end

    // NOTE: the table is constant, so only the read registers are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin <= '0;
            r_cos <= '0;
        end else begin
            r_sin <= w_table[i_sin_addr];
            r_cos <= w_table[i_cos_addr];
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;

endmodule

// File: rtl/qpsk_carrier_mod.sv
// QPSK carrier modulator: NCO + sine ROM, mod_out = I*cos(phi) - Q*sin(phi), 4-edge latency.
// Optional QPSK_MOD_PHASE_SYNC_EN restarts the carrier at phase 0 on every symbol change.
module qpsk_carrier_mod
    import qpsk_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int FTW     = FTW_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             I,
    input  logic [1:0]             Q,
    output logic signed [DATA_W:0] mod_out,
    output logic                   cyc_start
);

    localparam int                 SW      = DATA_W + 1;
    localparam logic [PHASE_W:0]   FTW_EXT = (PHASE_W + 1)'(FTW);
    localparam logic [LUT_AW-1:0]  COS_OFS = LUT_AW'(1 << (LUT_AW - 2));

    logic [PHASE_W-1:0]     r_acc;
    logic                   r_wrap0, r_wrap1, r_wrap2;
    logic [1:0]             r_i0, r_q0, r_i1, r_q1;
    logic signed [DATA_W:0] r_p_i, r_p_q;
    logic signed [DATA_W:0] r_mod_out;
    logic                   r_cyc;

    logic [PHASE_W:0]         w_sum;
    logic [LUT_AW-1:0]        w_addr;
    logic [LUT_AW-1:0]        w_cos_addr;
    logic signed [DATA_W-1:0] w_sin, w_cos;
    logic signed [DATA_W+1:0] w_diff;

    function automatic logic signed [DATA_W:0] bp_scale(input logic [1:0] code,
                                                        input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W:0] ext;
        ext = SW'(v);
        case (code)
            BP_POS:  return ext;
            BP_NEG:  return -ext;
            default: return '0;
        endcase
    endfunction

    assign w_sum      = {1'b0, r_acc} + FTW_EXT;
    assign w_addr     = r_acc[PHASE_W-1 -: LUT_AW];
    assign w_cos_addr = w_addr + COS_OFS;   // wraps modulo 2^LUT_AW
    assign w_diff     = (DATA_W + 2)'(r_p_i) - (DATA_W + 2)'(r_p_q);

    qpsk_sin_rom #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sin_addr (w_addr),
        .i_cos_addr (w_cos_addr),
        .o_sin      (w_sin),
        .o_cos      (w_cos)
    );

    // NOTE: non-blocking assignments keep every stage reading last cycle's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_wrap0   <= 1'b0;
            r_wrap1   <= 1'b0;
            r_wrap2   <= 1'b0;
            r_i0      <= '0;
            r_q0      <= '0;
            r_i1      <= '0;
            r_q1      <= '0;
            r_p_i     <= '0;
            r_p_q     <= '0;
            r_mod_out <= '0;
            r_cyc     <= 1'b0;
        end else begin
            r_i0 <= I;
            r_q0 <= Q;
`ifdef QPSK_MOD_PHASE_SYNC_EN
            if ({I, Q} != {r_i0, r_q0}) begin
                r_acc   <= '0;
                r_wrap0 <= 1'b1;
            end else begin
                {r_wrap0, r_acc} <= w_sum;
            end
`else
            {r_wrap0, r_acc} <= w_sum;
`endif
            r_i1    <= r_i0;
            r_q1    <= r_q0;
            r_wrap1 <= r_wrap0;

            r_p_i   <= bp_scale(r_i1, w_cos);
            r_p_q   <= bp_scale(r_q1, w_sin);
            r_wrap2 <= r_wrap1;

            r_mod_out <= SW'(sat_sym(int'(w_diff), DATA_W));
            r_cyc     <= r_wrap2;
        end
    end

    assign mod_out   = r_mod_out;
    assign cyc_start = r_cyc;

endmodule

// File: tb/tb_qpsk_carrier_mod.sv
// Self-checking bench for qpsk_carrier_mod: four instances with different FTW share I/Q and
// reset; a phase/ROM reference model pushes expected samples, popped on each falling edge.
module tb_qpsk_carrier_mod;
    import qpsk_pkg::*;

    localparam int NI = 4;

    typedef struct {
        int m;
        int c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       I, Q;
    logic signed [8:0] mo [NI];
    logic             cs [NI];

    exp_t        sb [NI][$];
    int          rom_ref [256];
    logic [23:0] m_acc [NI];
    logic [1:0]  m_i, m_q;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #10 clk = ~clk;

    qpsk_carrier_mod #(.FTW(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .I(I), .Q(Q), .mod_out(mo[0]), .cyc_start(cs[0]));
    qpsk_carrier_mod #(.FTW(1 << 22)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .I(I), .Q(Q), .mod_out(mo[1]), .cyc_start(cs[1]));
    qpsk_carrier_mod #(.FTW(3355)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .I(I), .Q(Q), .mod_out(mo[2]), .cyc_start(cs[2]));
    qpsk_carrier_mod #(.FTW(1 << 21)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .I(I), .Q(Q), .mod_out(mo[3]), .cyc_start(cs[3]));

    function automatic int ftw_of(input int g);
        case (g)
            0:       return 0;
            1:       return 1 << 22;
            2:       return 3355;
            default: return 1 << 21;
        endcase
    endfunction

    function automatic int bp_val(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b11) return -1;
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int expd, input int tol = 0);
        int d;
        n_checks++;
        d = obs - expd;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expd, $time);
        end
    endtask

    // Reference model: new phase per rising edge, expected sample emerges 3 edges later.
    logic [24:0] t_sum;
    logic [23:0] t_acc;
    int          t_wrap, t_a, t_v;
    exp_t        t_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_i = '0;
            m_q = '0;
            for (int g = 0; g < NI; g++) begin
                m_acc[g] = '0;
                sb[g].delete();
                t_e.m = 0;
                t_e.c = 0;
                repeat (3) sb[g].push_back(t_e);
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                t_sum  = {1'b0, m_acc[g]} + 25'(ftw_of(g));
                t_acc  = t_sum[23:0];
                t_wrap = int'(t_sum[24]);
`ifdef QPSK_MOD_PHASE_SYNC_EN
                if ({I, Q} != {m_i, m_q}) begin
                    t_acc  = '0;
                    t_wrap = 1;
                end
`endif
                m_acc[g] = t_acc;
                t_a = int'(t_acc[23:16]);
                t_v = bp_val(I) * rom_ref[(t_a + 64) % 256] - bp_val(Q) * rom_ref[t_a];
                if (t_v > 255)  t_v = 255;
                if (t_v < -255) t_v = -255;
                t_e.m = t_v;
                t_e.c = t_wrap;
                sb[g].push_back(t_e);
            end
            m_i = I;
            m_q = Q;
        end
    end

    exp_t c_e;
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n || sb[g].size() <= 3) begin
                check($sformatf("idle_mod%0d", g), int'(mo[g]), 0);
                check($sformatf("idle_cyc%0d", g), int'(cs[g]), 0);
            end else begin
                c_e = sb[g].pop_front();
                check($sformatf("mod%0d", g), int'(mo[g]), c_e.m, (g == 2) ? 1 : 0);
                check($sformatf("cyc%0d", g), int'(cs[g]), c_e.c);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_iq(input logic [1:0] i_v, input logic [1:0] q_v, input int n);
        I = i_v;
        Q = q_v;
        run(n);
    endtask

    initial begin
        real x;
        for (int k = 0; k < 256; k++) begin
            x = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
            rom_ref[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        end
        I     = 2'b00;
        Q     = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with random symbols: outputs stay at zero.
        repeat (5) begin
            run(1);
            I = 2'($urandom);
            Q = 2'($urandom);
        end
        run(1);
        rst_n = 1'b1;

        // Constant-phase patterns, then quarter-rate carrier.
        set_iq(2'b01, 2'b01, 8);
        set_iq(2'b11, 2'b01, 6);
        set_iq(2'b01, 2'b00, 6);
        set_iq(2'b00, 2'b00, 6);
        set_iq(2'b01, 2'b01, 16);

        // One full carrier period at the default tuning word.
        set_iq(2'b01, 2'b11, 5001);

        // Symbol toggles at arbitrary phases.
        for (int k = 0; k < 12; k++)
            set_iq((k % 2 == 0) ? 2'b11 : 2'b01, 2'b01, int'($urandom_range(3, 9)));

        // Reset mid-stream: outputs clear immediately, then the run restarts.
        run(int'($urandom_range(1, 3)));
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_mod%0d", g), int'(mo[g]), 0);
            check($sformatf("rst_cyc%0d", g), int'(cs[g]), 0);
        end
        run(2);
        rst_n = 1'b1;
        set_iq(2'b01, 2'b01, 16);
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
